// File: rtl/exec_pkg.sv
// exec_pkg: shared opcode/fault types and op classification for the execute stage
package exec_pkg;
  localparam int XLEN = 32;

  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA, OP_SLT, OP_SLTU, OP_LUI,
    OP_JAL, OP_JALR, OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW
  } exec_op_t;

  typedef enum logic [1:0] {FC_NONE, FC_RD, FC_MISALIGN, FC_TIMEOUT} fault_cause_t;

  function automatic logic is_load(exec_op_t op);
    return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
  endfunction

  function automatic logic is_store(exec_op_t op);
    return op inside {OP_SB, OP_SH, OP_SW};
  endfunction

  function automatic logic is_ctrl(exec_op_t op);
    return op inside {OP_JAL, OP_JALR, OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU};
  endfunction

  function automatic logic writes_rd(exec_op_t op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA,
                      OP_SLT, OP_SLTU, OP_LUI, OP_JAL, OP_JALR} || is_load(op);
  endfunction
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational ALU result and branch condition for one op
module alu_core import exec_pkg::*; (
  input  exec_op_t          op,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic [XLEN-1:0]   result,
  output logic              taken
);
  // arithmetic/logic result; LUI passes operand B (the immediate) through
  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_SLL:  result = a << b[4:0];
      OP_SRL:  result = a >> b[4:0];
      OP_SRA:  result = $signed(a) >>> b[4:0];
      OP_SLT:  result = {{XLEN-1{1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: result = {{XLEN-1{1'b0}}, a < b};
      OP_LUI:  result = b;
      default: result = '0;
    endcase
  end

  // control-flow condition; jumps are always taken
  always_comb begin
    taken = 1'b0;
    case (op)
      OP_JAL, OP_JALR: taken = 1'b1;
      OP_BEQ:  taken = a == b;
      OP_BNE:  taken = a != b;
      OP_BLT:  taken = $signed(a) < $signed(b);
      OP_BGE:  taken = $signed(a) >= $signed(b);
      OP_BLTU: taken = a < b;
      OP_BGEU: taken = a >= b;
      default: taken = 1'b0;
    endcase
  end
endmodule

// File: rtl/execute_unit_mc.sv
// execute_unit_mc: multi-cycle execute stage with ALU, control flow, load/store and sticky fault
module execute_unit_mc import exec_pkg::*; #(
  parameter int REG_COUNT   = 16,
  parameter int BUS_TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_op,
  input  logic        in_use_imm,
  input  logic [31:0] in_rs1_val,
  input  logic [31:0] in_rs2_val,
  input  logic [31:0] in_imm,
  input  logic [31:0] in_pc,
  input  logic [4:0]  in_rd,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  output logic        bus_read,
  output logic        bus_write,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        wb_en,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        fault,
  output logic [1:0]  fault_cause
);
  typedef enum logic [1:0] {S_IDLE, S_MEM, S_FAULT} state_t;

  localparam logic [5:0] RC = 6'(REG_COUNT);

  state_t          state, state_next;
  exec_op_t        op, mem_op;
  fault_cause_t    err;
  logic [XLEN-1:0] alu_b, alu_result, mem_addr, target, shifted, load_val;
  logic            taken, accept, is_mem, rd_bad, misaligned, timeout_hit, mem_load;
  logic [1:0]      mem_off;
  logic [4:0]      mem_rd;
  logic [15:0]     wait_cnt;

  assign op          = exec_op_t'(in_op);
  assign alu_b       = (in_use_imm && !is_ctrl(op)) || op == OP_LUI ? in_imm : in_rs2_val;
  assign mem_addr    = in_rs1_val + in_imm;
  assign target      = op == OP_JALR ? mem_addr & ~32'd1 : in_pc + in_imm;
  assign is_mem      = is_load(op) || is_store(op);
  assign rd_bad      = writes_rd(op) && {1'b0, in_rd} >= RC;
  assign misaligned  = is_ctrl(op) ? taken && target[1]
                     : (op inside {OP_LH, OP_LHU, OP_SH} && mem_addr[0]) ||
                       (op inside {OP_LW, OP_SW} && mem_addr[1:0] != 2'b00);
  assign err         = rd_bad ? FC_RD : misaligned ? FC_MISALIGN : FC_NONE;
  assign in_ready    = state == S_IDLE;
  assign accept      = in_valid && in_ready;
  assign timeout_hit = wait_cnt + 16'd1 == 16'(BUS_TIMEOUT);
  assign bus_read    = state == S_MEM && mem_load;
  assign bus_write   = state == S_MEM && !mem_load;
  assign shifted     = bus_rdata >> {mem_off, 3'b000};
  assign load_val    = mem_op == OP_LB  ? {{24{shifted[7]}}, shifted[7:0]}
                     : mem_op == OP_LBU ? {24'd0, shifted[7:0]}
                     : mem_op == OP_LH  ? {{16{shifted[15]}}, shifted[15:0]}
                     : mem_op == OP_LHU ? {16'd0, shifted[15:0]}
                     : bus_rdata;

  alu_core u_alu (
    .op     (op),
    .a      (in_rs1_val),
    .b      (alu_b),
    .result (alu_result),
    .taken  (taken)
  );

  // state register; reset drops any bus request immediately
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= S_IDLE;
    else state <= state_next;

  // next state: faults are terminal, a bus access ends on ack or timeout
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (accept) state_next = err != FC_NONE ? S_FAULT : is_mem ? S_MEM : S_IDLE;
      S_MEM:   state_next = bus_ack ? S_IDLE : timeout_hit ? S_FAULT : S_MEM;
      default: state_next = S_FAULT;
    endcase
  end

  // registered results, bus request fields, timeout counter and sticky fault
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wb_en          <= 1'b0;
      wb_rd          <= '0;
      wb_data        <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      fault          <= 1'b0;
      fault_cause    <= '0;
      bus_addr       <= '0;
      bus_wdata      <= '0;
      bus_wstrb      <= '0;
      mem_load       <= 1'b0;
      mem_off        <= '0;
      mem_op         <= OP_ADD;
      mem_rd         <= '0;
      wait_cnt       <= '0;
    end else begin
      wb_en          <= 1'b0;
      redirect_valid <= 1'b0;
      if (state == S_MEM) begin
        wait_cnt <= wait_cnt + 16'd1;
        if (bus_ack) begin
          wb_en   <= mem_load && mem_rd != 5'd0;
          wb_rd   <= mem_rd;
          wb_data <= load_val;
        end else if (timeout_hit) begin
          fault       <= 1'b1;
          fault_cause <= FC_TIMEOUT;
        end
      end else if (accept) begin
        if (err != FC_NONE) begin
          fault       <= 1'b1;
          fault_cause <= err;
        end else if (is_mem) begin
          wait_cnt  <= '0;
          mem_load  <= is_load(op);
          mem_off   <= mem_addr[1:0];
          mem_op    <= op;
          mem_rd    <= in_rd;
          bus_addr  <= {mem_addr[31:2], 2'b00};
          bus_wdata <= op == OP_SB ? {4{in_rs2_val[7:0]}} : op == OP_SH ? {2{in_rs2_val[15:0]}} : in_rs2_val;
          bus_wstrb <= op == OP_SB ? 4'b0001 << mem_addr[1:0]
                     : op == OP_SH ? 4'b0011 << mem_addr[1:0]
                     : op == OP_SW ? 4'hF : 4'h0;
        end else if (is_ctrl(op)) begin
          redirect_valid <= taken;
          redirect_pc    <= target;
          wb_en          <= writes_rd(op) && in_rd != 5'd0;
          wb_rd          <= in_rd;
          wb_data        <= in_pc + 32'd4;
        end else if (writes_rd(op)) begin
          wb_en   <= in_rd != 5'd0;
          wb_rd   <= in_rd;
          wb_data <= alu_result;
        end
      end
    end
  end
endmodule

// File: tb/tb_execute_unit_mc.sv
// tb_execute_unit_mc: random and directed stimulus checked against a transaction-level model
module tb_execute_unit_mc;
  import exec_pkg::*;

  localparam int REG_CNT = 16;
  localparam int BUS_TO  = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid, in_ready, in_use_imm, bus_read, bus_write, bus_ack;
  logic        wb_en, redirect_valid, fault;
  logic [4:0]  in_op, in_rd, wb_rd;
  logic [31:0] in_rs1_val, in_rs2_val, in_imm, in_pc, bus_addr, bus_wdata, bus_rdata, wb_data, redirect_pc;
  logic [3:0]  bus_wstrb;
  logic [1:0]  fault_cause;

  int checks = 0;
  int errors = 0;

  int          ack_delay  = 0;
  bit          rand_rdata = 1'b1;
  logic [31:0] fixed_rdata = '0;

  int          m_mode;
  int          m_wait;
  int          m_op;
  logic        m_load;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_wstrb;
  logic [1:0]  m_off;
  logic [4:0]  m_rd;
  logic        e_wb_en, e_rv, e_fault;
  logic [4:0]  e_wb_rd;
  logic [31:0] e_wb_data, e_rpc;
  logic [1:0]  e_cause;

  execute_unit_mc #(.REG_COUNT(REG_CNT), .BUS_TIMEOUT(BUS_TO)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_use_imm(in_use_imm),
    .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_imm(in_imm), .in_pc(in_pc), .in_rd(in_rd),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_read(bus_read), .bus_write(bus_write), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fault(fault), .fault_cause(fault_cause)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SLL:  return a << (b % 32);
      OP_SRL:  return a >> (b % 32);
      OP_SRA:  return 32'($signed(64'($signed(a))) >>> (b % 32));
      OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
      default: return b;
    endcase
  endfunction

  function automatic bit ref_taken(input int op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      OP_BEQ:  return a == b;
      OP_BNE:  return a != b;
      OP_BLT:  return $signed(a) < $signed(b);
      OP_BGE:  return !($signed(a) < $signed(b));
      OP_BLTU: return a < b;
      OP_BGEU: return !(a < b);
      default: return 1'b1;
    endcase
  endfunction

  function automatic int size_of(input int op);
    if (op inside {OP_LB, OP_LBU, OP_SB}) return 1;
    if (op inside {OP_LH, OP_LHU, OP_SH}) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] load_ext(input int op, input logic [31:0] rd, input logic [1:0] off);
    logic [31:0] v;
    int sz;
    sz = size_of(op);
    v = rd >> (8 * off);
    if (sz == 1) v = v & 32'hFF;
    if (sz == 2) v = v & 32'hFFFF;
    if (op == OP_LB && v[7]) v = v | 32'hFFFFFF00;
    if (op == OP_LH && v[15]) v = v | 32'hFFFF0000;
    return v;
  endfunction

  task automatic model_fault(input logic [1:0] c);
    e_fault = 1'b1;
    e_cause = c;
    m_mode  = 2;
  endtask

  task automatic model_accept();
    int op, sz;
    logic [31:0] addr, tgt;
    bit tk;
    op   = int'(in_op);
    addr = in_rs1_val + in_imm;
    if (op inside {[OP_ADD:OP_JALR], [OP_LB:OP_LHU]} && int'(in_rd) >= REG_CNT) model_fault(2'd1);
    else if (op >= OP_LB) begin
      sz = size_of(op);
      if (addr % sz != 0) model_fault(2'd2);
      else begin
        m_mode  = 1;
        m_wait  = 0;
        m_op    = op;
        m_rd    = in_rd;
        m_load  = op <= OP_LHU;
        m_addr  = addr & ~32'd3;
        m_off   = 2'(addr % 4);
        m_wstrb = m_load ? 4'd0 : 4'(((1 << sz) - 1) << m_off);
        m_wdata = sz == 1 ? in_rs2_val[7:0] * 32'h01010101
                : sz == 2 ? in_rs2_val[15:0] * 32'h00010001 : in_rs2_val;
      end
    end else if (op >= OP_JAL) begin
      tgt = op == OP_JALR ? addr & ~32'd1 : in_pc + in_imm;
      tk  = ref_taken(op, in_rs1_val, in_rs2_val);
      if (tk && tgt[1]) model_fault(2'd2);
      else begin
        e_rv  = tk;
        e_rpc = tgt;
        if (op <= OP_JALR && in_rd != 0) begin
          e_wb_en   = 1'b1;
          e_wb_rd   = in_rd;
          e_wb_data = in_pc + 4;
        end
      end
    end else if (in_rd != 0) begin
      e_wb_en   = 1'b1;
      e_wb_rd   = in_rd;
      e_wb_data = ref_alu(op, in_rs1_val, (op == OP_LUI || in_use_imm) ? in_imm : in_rs2_val);
    end
  endtask

  initial forever begin
    @(posedge clock or negedge reset);
    if (!reset) begin
      m_mode = 0; m_wait = 0; m_load = 0;
      e_wb_en = 0; e_rv = 0; e_fault = 0; e_cause = 0;
    end else begin
      e_wb_en = 1'b0;
      e_rv    = 1'b0;
      if (m_mode == 1) begin
        if (bus_ack) begin
          m_mode = 0;
          if (m_load && m_rd != 0) begin
            e_wb_en   = 1'b1;
            e_wb_rd   = m_rd;
            e_wb_data = load_ext(m_op, bus_rdata, m_off);
          end
        end else begin
          m_wait++;
          if (m_wait == BUS_TO) model_fault(2'd3);
        end
      end else if (m_mode == 0 && in_valid) model_accept();
    end
  end

  initial forever begin
    @(negedge clock);
    chk("in_ready", in_ready, m_mode == 0);
    chk("bus_read", bus_read, m_mode == 1 && m_load);
    chk("bus_write", bus_write, m_mode == 1 && !m_load);
    if (m_mode == 1) begin
      chk("bus_addr", bus_addr, m_addr);
      chk("bus_wstrb", bus_wstrb, m_wstrb);
      if (!m_load) chk("bus_wdata", bus_wdata, m_wdata);
    end
    chk("wb_en", wb_en, e_wb_en);
    if (e_wb_en) begin
      chk("wb_rd", wb_rd, e_wb_rd);
      chk("wb_data", wb_data, e_wb_data);
    end
    chk("redirect_valid", redirect_valid, e_rv);
    if (e_rv) chk("redirect_pc", redirect_pc, e_rpc);
    chk("fault", fault, e_fault);
    chk("fault_cause", fault_cause, e_cause);
  end

  initial begin
    int w, tgt;
    w = 0;
    tgt = 0;
    bus_ack = 1'b0;
    bus_rdata = '0;
    forever begin
      @(negedge clock);
      bus_ack = 1'b0;
      if (bus_read || bus_write) begin
        if (w == 0) tgt = ack_delay == -2 ? int'($urandom_range(0, BUS_TO - 1)) : ack_delay;
        if (tgt >= 0 && w == tgt) begin
          bus_ack   = 1'b1;
          bus_rdata = rand_rdata ? $urandom : fixed_rdata;
        end
        w++;
      end else w = 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic issue(input int op, input logic ui, input logic [31:0] r1, input logic [31:0] r2,
                       input logic [31:0] im, input logic [31:0] pc, input logic [4:0] rd);
    int n;
    logic r;
    n = 0;
    in_valid = 1'b1; in_op = 5'(op); in_use_imm = ui;
    in_rs1_val = r1; in_rs2_val = r2; in_imm = im; in_pc = pc; in_rd = rd;
    do begin
      r = in_ready;
      @(negedge clock);
      n++;
    end while (!r && n < 64);
    chk("issue_accept", r, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clock); #2 reset = 1'b0;
    @(posedge clock); #2 reset = 1'b1;
    @(negedge clock);
  endtask

  initial begin
    int op, sz, n;
    logic [31:0] r1, r2, im, pc, a;
    logic [4:0] rd;
    in_valid = 0; in_op = 0; in_use_imm = 0; in_rs1_val = 0; in_rs2_val = 0;
    in_imm = 0; in_pc = 0; in_rd = 0;
    repeat (2) @(negedge clock);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_wb_en", wb_en, 1'b0);
    chk("rst_bus_read", bus_read, 1'b0);
    chk("rst_redirect", redirect_valid, 1'b0);
    chk("rst_fault", fault, 1'b0);
    @(posedge clock); #2 reset = 1'b1;
    @(negedge clock);

    issue(OP_ADD, 0, 5, 7, 0, 0, 3);
    chk("add_wb_en", wb_en, 1'b1);
    chk("add_wb_rd", wb_rd, 5'd3);
    chk("add_wb_data", wb_data, 32'd12);
    chk("add_in_ready", in_ready, 1'b1);
    issue(OP_BLT, 0, 32'hFFFFFFFF, 1, 32'hFFFFFFF8, 32'h100, 0);
    chk("blt_redirect", redirect_valid, 1'b1);
    chk("blt_pc", redirect_pc, 32'hF8);
    chk("blt_wb_en", wb_en, 1'b0);
    issue(OP_BLTU, 0, 32'hFFFFFFFF, 1, 32'hFFFFFFF8, 32'h100, 0);
    chk("bltu_redirect", redirect_valid, 1'b0);

    ack_delay = 2;
    issue(OP_SB, 0, 32'h1000, 32'hAB, 2, 0, 0);
    for (int i = 0; i < 3; i++) begin
      chk("sb_write", bus_write, 1'b1);
      chk("sb_addr", bus_addr, 32'h1000);
      chk("sb_wstrb", bus_wstrb, 4'b0100);
      chk("sb_wdata", bus_wdata, 32'hABABABAB);
      chk("sb_in_ready", in_ready, 1'b0);
      @(negedge clock);
    end
    chk("sb_ready_after", in_ready, 1'b1);
    chk("sb_write_after", bus_write, 1'b0);

    ack_delay = 0; rand_rdata = 0; fixed_rdata = 32'h80010000;
    issue(OP_LH, 1, 32'h2000, 0, 2, 0, 5);
    @(negedge clock);
    chk("lh_wb_en", wb_en, 1'b1);
    chk("lh_wb_data", wb_data, 32'hFFFF8001);
    issue(OP_LHU, 1, 32'h2000, 0, 2, 0, 5);
    @(negedge clock);
    chk("lhu_wb_data", wb_data, 32'h00008001);

    ack_delay = BUS_TO - 1; fixed_rdata = 32'h12345678;
    issue(OP_LW, 1, 32'h40, 0, 0, 0, 6);
    repeat (BUS_TO) @(negedge clock);
    chk("late_ack_wb_data", wb_data, 32'h12345678);
    chk("late_ack_fault", fault, 1'b0);

    ack_delay = -2; rand_rdata = 1;
    for (int k = 0; k < 400; k++) begin
      op = $urandom_range(0, 26);
      r1 = $urandom; r2 = $urandom; im = $urandom; pc = $urandom & ~32'd3;
      rd = 5'($urandom_range(0, REG_CNT - 1));
      if ($urandom_range(0, 3) == 0) begin
        r1 = $urandom_range(0, 4);
        r2 = $urandom_range(0, 4);
      end
      if (op >= OP_LB) begin
        sz = size_of(op);
        a = r1 + im;
        im = im - (a % sz);
      end else if (op >= OP_JAL) begin
        im = im & ~32'd3;
        if (op == OP_JALR) r1 = r1 & ~32'd2;
      end
      if ($urandom_range(0, 4) == 0) @(negedge clock);
      issue(op, 1'($urandom), r1, r2, im, pc, rd);
    end
    repeat (BUS_TO + 2) @(negedge clock);

    do_reset();
    issue(OP_ADD, 1, 1, 2, 3, 0, 17);
    chk("rd_fault", fault, 1'b1);
    chk("rd_cause", fault_cause, 2'd1);
    chk("rd_wb_en", wb_en, 1'b0);
    chk("rd_in_ready", in_ready, 1'b0);
    in_valid = 1'b1; in_op = 5'(OP_LW); in_rs1_val = 3; in_imm = 0; in_rd = 2;
    repeat (3) @(negedge clock);
    in_valid = 1'b0;
    chk("rd_sticky_cause", fault_cause, 2'd1);
    chk("rd_sticky_ready", in_ready, 1'b0);

    do_reset();
    issue(OP_LW, 1, 0, 0, 3, 0, 4);
    chk("mis_fault", fault, 1'b1);
    chk("mis_cause", fault_cause, 2'd2);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus_read) n++;
      @(negedge clock);
    end
    chk("mis_no_read", n, 0);

    do_reset();
    ack_delay = -1;
    issue(OP_LW, 1, 32'h40, 0, 0, 0, 4);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus_read) n++;
      @(negedge clock);
    end
    chk("to_read_cycles", n, BUS_TO);
    chk("to_fault", fault, 1'b1);
    chk("to_cause", fault_cause, 2'd3);
    chk("to_in_ready", in_ready, 1'b0);

    do_reset();
    issue(OP_LW, 1, 32'h40, 0, 0, 0, 4);
    chk("mid_read", bus_read, 1'b1);
    @(negedge clock);
    @(posedge clock); #2 reset = 1'b0;
    #1;
    chk("mid_async_read", bus_read, 1'b0);
    chk("mid_async_ready", in_ready, 1'b1);
    @(posedge clock); #2 reset = 1'b1;
    @(negedge clock);
    issue(OP_SUB, 0, 10, 3, 0, 0, 9);
    chk("post_rst_wb_data", wb_data, 32'd7);
    @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/execute_unit_mc.md
Name: execute_unit_mc

Overview:
- Parametrised, multi-cycle execute stage for the rv32 core. Sits between the decode stage's skid-buffer output and the register-file write port and data bus.
- Executes ALU, branch/jump and load/store ops with a valid/ready upstream handshake.
- Stalls upstream during bus accesses, redirects fetch on taken control flow, and latches a sticky fault on illegal conditions.
- Generalises the register count (RV32E/RV32I) and adds a bus timeout.

Parameters:
- REG_COUNT, 16, architectural registers (16 = RV32E, 32 = RV32I); rd/rs indices >= REG_COUNT are illegal.
- BUS_TIMEOUT, 255, max cycles waiting for bus_ack before fault (1..65535).

Ports:
- clock  in  1  clock
- reset  in  1  asynchronous active-low reset
- in_valid  in  1  decoded instruction available
- in_ready  out  1  stage can accept
- in_op  in  5  exec_op_t opcode
- in_use_imm  in  1  ALU operand B = in_imm (else in_rs2_val)
- in_rs1_val  in  32  rs1 value
- in_rs2_val  in  32  rs2 value / store data
- in_imm  in  32  sign-extended immediate (branch/jump offset for control ops)
- in_pc  in  32  instruction PC
- in_rd  in  5  destination index
- bus_addr  out  32  byte address, word-aligned (addr & ~3)
- bus_wdata  out  32  store data replicated into lanes
- bus_wstrb  out  4  byte enables
- bus_read  out  1  read request
- bus_write  out  1  write request
- bus_rdata  in  32  read data, valid with bus_ack
- bus_ack  in  1  access complete
- wb_en  out  1  one-cycle write-back strobe
- wb_rd  out  5  write-back index
- wb_data  out  32  write-back value
- redirect_valid  out  1  one-cycle fetch redirect
- redirect_pc  out  32  redirect target
- fault  out  1  sticky fault
- fault_cause  out  2  0 none, 1 illegal rd, 2 misaligned, 3 bus timeout

Behaviour:
- Reset (async, active-low):
  - State IDLE; in_ready=1.
  - All other outputs 0; timeout counter 0.
- States:
  - IDLE: in_ready=1. Accept on in_valid&&in_ready.
  - MEM: in_ready=0. Bus request held stable until bus_ack.
  - FAULT: in_ready=0, no requests; left only by reset.
- ALU ops:
  - Ops: ADD SUB AND OR XOR SLL SRL SRA SLT SLTU LUI.
  - Result registered; wb_en pulses the cycle after acceptance. Back-to-back issue gives 1 op/cycle.
  - Shifts use operand B[4:0]. SLT is signed, SLTU unsigned. LUI writes in_imm.
  - All arithmetic is mod 2^32.
- Control ops:
  - Ops: JAL JALR BEQ BNE BLT BGE BLTU BGEU.
  - Targets: JAL/branch target = in_pc + in_imm. JALR target = (rs1 + imm) & ~1.
  - JAL/JALR write pc+4 to rd.
  - Taken branch/jump: redirect_valid pulses with redirect_pc in the cycle after acceptance, coincident with any wb_en. Not-taken: no redirect.
  - Target[1] set -> misaligned fault; no wb, no redirect.
- Load/store:
  - Ops: LB LH LW LBU LHU SB SH SW.
  - Address = rs1 + imm.
  - Misaligned (LH/SH addr[0]; LW/SW addr[1:0] != 0) -> fault cause 2, no bus request.
  - Otherwise enter MEM next cycle with bus_read/bus_write asserted.
  - wstrb: SB 1<<addr[1:0]; SH 3<<addr[1:0]; SW 4'hF. Loads drive wstrb=0.
  - On bus_ack: request deasserted next cycle, return to IDLE (in_ready=1 that cycle).
  - Loads: wb_en pulses the cycle after bus_ack, carrying the extracted and sign/zero-extended lane.
- Write-back suppression:
  - rd==0: wb_en suppressed, redirect unaffected.
  - rd >= REG_COUNT on any rd-writing op: fault cause 1; no wb, no redirect, no bus access.
- Timeout:
  - Counter clears on entering MEM and increments each MEM cycle without ack.
  - Reaching BUS_TIMEOUT: drop request, enter FAULT, cause 3.
  - bus_ack in the same cycle the count reaches BUS_TIMEOUT counts as success.
- Fault:
  - fault and fault_cause latch; the first cause wins.
  - The faulting instruction is consumed and in_ready drops the following cycle.
- Stores: never write back.
- Reset mid-MEM: request drops immediately (asynchronous).

Decomposition:
- Package exec_pkg holds:
  - exec_op_t enum.
  - fault_cause_t.
  - XLEN=32.
  - Helper functions is_load, is_store, is_ctrl, writes_rd.
- One combinational sub-module, alu_core: op, a, b -> result, plus branch compare flag. FSM, LSU lane logic and timeout stay in the top.

Test Plan:
- Reset, then ADD rs1=5, rs2=7, rd=3 -> next cycle wb_en=1, wb_rd=3, wb_data=12; in_ready stays 1.
- BLT rs1=0xFFFFFFFF, rs2=1, pc=0x100, imm=-8 -> redirect_valid pulse, redirect_pc=0xF8, no wb_en. Same with BLTU -> no redirect.
- SB rs1=0x1000, imm=2, rs2=0xAB -> bus_write, addr=0x1000, wstrb=4'b0100, wdata=0xABABABAB held 3 cycles until ack; in_ready=0 throughout, 1 after.
- LH addr=0x2002, rdata=0x8001_0000 -> wb_data=0xFFFF8001. LHU -> 0x00008001.
- REG_COUNT=16, ADD rd=17 -> fault=1, cause=1, no wb, in_ready=0 until reset. LW addr=0x3 -> cause=2, bus_read never asserted.
- BUS_TIMEOUT=4, LW with no ack -> bus_read for 4 cycles, then fault cause=3. Assert reset mid-wait (second run) -> bus_read falls asynchronously, in_ready=1.
